// File: rtl/prio_encoder_pipe_pkg.sv
// Shared constants and width helper for the registered priority encoder.
package encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an n-bit request vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Request/result handshake bundle for prio_encoder_pipe.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid && !ready.
interface prio_encoder_pipe_if #(
    parameter int N = 8
) ();
    localparam int W = encoder_pkg::idx_width(N);

    logic [N-1:0] in;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_zero;
    logic         out_multi;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in, mode, in_valid, out_ready,
        output in_ready, out, out_zero, out_multi, out_valid
    );

    modport master (
        output in, mode, in_valid, out_ready,
        input  in_ready, out, out_zero, out_multi, out_valid
    );
endinterface

// File: rtl/prio_encoder_pipe_ffs_from.sv
// Combinational find-first-set searching upward from start_i, wrapping N-1 -> 0.
module ffs_from
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic         hi_found;
    logic         lo_found;

    // Descending scan so the lowest qualifying bit is the last one written.
    // "hi" covers bits at or above start; "lo" is the wrapped fallback.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                lo_idx   = W'(i);
                lo_found = 1'b1;
                if (W'(i) >= start_i) begin
                    hi_idx   = W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign idx_o   = hi_found ? hi_idx : lo_idx;
    assign found_o = lo_found;

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-bit priority encoder with fixed and round-robin modes,
// zero/multi-hot flags and valid/ready on both sides.
module prio_encoder_pipe
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_encoder_pipe_if.slave   bus,
    output logic [W-1:0]         ptr_o
);

    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         fix_found;
    logic         rr_found;
    logic [W-1:0] sel;
    logic         accept;

    logic [W-1:0] out_q,   out_d;
    logic         zero_q,  zero_d;
    logic         multi_q, multi_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q,   ptr_d;

    ffs_from #(.N(N)) u_ffs_fix (
        .vec_i   (bus.in),
        .start_i ('0),
        .idx_o   (fix_idx),
        .found_o (fix_found)
    );

    ffs_from #(.N(N)) u_ffs_rr (
        .vec_i   (bus.in),
        .start_i (ptr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    assign sel          = (bus.mode == MODE_RR) ? rr_idx : fix_idx;
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_d   = out_q;
        zero_d  = zero_q;
        multi_d = multi_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (accept) begin
            out_d   = sel;
            zero_d  = !fix_found;
            // Clearing the lowest set bit leaves something only if popcount > 1.
            multi_d = |(bus.in & (bus.in - N'(1)));
            valid_d = 1'b1;
            if (bus.mode == MODE_RR && rr_found) begin
                ptr_d = (rr_idx == W'(N - 1)) ? '0 : rr_idx + W'(1);
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            out_q   <= out_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_multi = multi_q;
    assign bus.out_valid = valid_q;
    assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Randomized and directed checks of prio_encoder_pipe against a queue-based reference.
module tb_prio_encoder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] ptr8;
    logic [2:0] ptr6;

    int n_checks = 0;
    int n_pass = 0;

    // Expected entry packing: {index[2:0], zero, multi}
    localparam int EW = 5;
    logic [EW-1:0] exp_q[$];
    int mptr = 0;

    prio_encoder_pipe_if #(.N(8)) bus8 ();
    prio_encoder_pipe_if #(.N(6)) bus6 ();

    prio_encoder_pipe #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8),
        .ptr_o (ptr8)
    );

    prio_encoder_pipe #(.N(6)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6),
        .ptr_o (ptr6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: scan positions start, start+1, ... modulo 8 for the first set bit.
    function automatic int ref_sel(input logic [7:0] v, input logic m, input int p);
        int start;
        start = m ? p : 0;
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (((v >> j) & 8'd1) != 8'd0) return j;
        end
        return 0;
    endfunction

    // Scoreboard/monitor for the N=8 instance, sampled mid-cycle.
    logic [EW-1:0] mon_e;
    int            mon_sel;
    bit            mon_has;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_has = exp_q.size() > 0;
            check("mon_out_valid", bus8.out_valid, mon_has);
            check("mon_in_ready", bus8.in_ready, !mon_has || bus8.out_ready);
            check("mon_ptr", ptr8, mptr);
            if (mon_has) begin
                check("mon_out", bus8.out, exp_q[0][4:2]);
                check("mon_zero", bus8.out_zero, exp_q[0][1]);
                check("mon_multi", bus8.out_multi, exp_q[0][0]);
                if (bus8.out_ready) void'(exp_q.pop_front());
            end
            if (bus8.in_valid && bus8.in_ready) begin
                mon_sel = ref_sel(bus8.in, bus8.mode, mptr);
                mon_e = {3'(mon_sel), bus8.in == 8'd0, $countones(bus8.in) > 1};
                exp_q.push_back(mon_e);
                if (bus8.mode && bus8.in != 8'd0) mptr = (mon_sel + 1) % 8;
            end
        end
    end

    task automatic send8(input logic [7:0] v, input logic m);
        int waited;
        waited = 0;
        bus8.in = v;
        bus8.mode = m;
        bus8.in_valid = 1'b1;
        while (!bus8.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus8.in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send6(input logic [5:0] v);
        bus6.in = v;
        bus6.mode = 1'b1;
        bus6.in_valid = 1'b1;
        @(posedge clk); #1;
        bus6.in_valid = 1'b0;
    endtask

    task automatic expect8(input string tag, input int idx, input logic z, input logic mh, input int p);
        check({tag, "_valid"}, bus8.out_valid, 1);
        check({tag, "_out"}, bus8.out, idx);
        check({tag, "_zero"}, bus8.out_zero, z);
        check({tag, "_multi"}, bus8.out_multi, mh);
        check({tag, "_ptr"}, ptr8, p);
    endtask

    initial begin
        bus8.in = '0; bus8.mode = 1'b0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        bus6.in = '0; bus6.mode = 1'b0; bus6.in_valid = 1'b0; bus6.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", bus8.out_valid, 0);
        check("rst_out", bus8.out, 0);
        check("rst_zero", bus8.out_zero, 0);
        check("rst_multi", bus8.out_multi, 0);
        check("rst_ptr", ptr8, 0);
        check("rst_in_ready", bus8.in_ready, 1);

        // Round-robin walk with wrap from 7 back to 0.
        send8(8'b1000_1001, 1'b1); expect8("rr0", 0, 1'b0, 1'b1, 1);
        send8(8'b1000_1001, 1'b1); expect8("rr1", 3, 1'b0, 1'b1, 4);
        send8(8'b1000_1001, 1'b1); expect8("rr2", 7, 1'b0, 1'b1, 0);

        send8(8'b0110_1000, 1'b0); expect8("fixed", 3, 1'b0, 1'b1, 0);
        send8(8'h00, 1'b1);        expect8("zero", 0, 1'b1, 1'b0, 0);

        // Mode switch keeps the round-robin pointer.
        send8(8'b0000_0100, 1'b1); expect8("rr_onehot", 2, 1'b0, 1'b0, 3);
        send8(8'b1000_0001, 1'b0); expect8("fix_keep_ptr", 0, 1'b0, 1'b1, 3);

        @(posedge clk); #1;
        check("drain_valid", bus8.out_valid, 0);

        // Backpressure then release with a new request at the same edge.
        bus8.out_ready = 1'b0;
        send8(8'b0010_0100, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check("bp_in_ready", bus8.in_ready, 0);
            expect8("bp_hold", 2, 1'b0, 1'b1, 3);
            @(posedge clk); #1;
        end
        bus8.out_ready = 1'b1;
        send8(8'b1100_0000, 1'b0); expect8("bp_release", 6, 1'b0, 1'b1, 3);

        // Random traffic; the monitor checks every cycle.
        for (int c = 0; c < 400; c++) begin
            int kind;
            kind = $urandom_range(0, 3);
            bus8.in_valid = ($urandom_range(0, 3) != 0);
            bus8.mode = 1'($urandom_range(0, 1));
            if (kind == 0)      bus8.in = 8'h00;
            else if (kind == 1) bus8.in = 8'd1 << $urandom_range(0, 7);
            else                bus8.in = 8'($urandom_range(0, 255));
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while a result is pending and ptr is 5.
        bus8.out_ready = 1'b0;
        send8(8'b0001_0000, 1'b1);
        expect8("pre_rst", 4, 1'b0, 1'b0, 5);
        #3 rst_n = 1'b0;
        exp_q.delete();
        mptr = 0;
        #1;
        check("arst_valid", bus8.out_valid, 0);
        check("arst_out", bus8.out, 0);
        check("arst_zero", bus8.out_zero, 0);
        check("arst_multi", bus8.out_multi, 0);
        check("arst_ptr", ptr8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        check("no_replay", bus8.out_valid, 0);

        // N=6: the pointer wraps at 6, not at 8.
        send6(6'b010000);
        check("n6_a_out", bus6.out, 4);
        check("n6_a_ptr", ptr6, 5);
        send6(6'b100001);
        check("n6_b_out", bus6.out, 5);
        check("n6_b_ptr", ptr6, 0);
        check("n6_b_multi", bus6.out_multi, 1);
        send6(6'b100001);
        check("n6_c_out", bus6.out, 0);
        check("n6_c_ptr", ptr6, 1);
        check("n6_c_valid", bus6.out_valid, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
